// File: rtl/top_level_pkg.sv
// Shared types, address map and SECDED helpers for the Hamming/pattern engine.
package top_level_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENC,
      ST_DEC,
      ST_PAT_RD,
      ST_PAT_WR,
      ST_FIN
   } state_t;

   typedef enum logic [1:0] {
      TASK_ENC = 2'd1,
      TASK_DEC = 2'd2,
      TASK_PAT = 2'd3
   } task_t;

   localparam logic [7:0] ADDR_ENC_SRC = 8'd0;
   localparam logic [7:0] ADDR_ENC_DST = 8'd30;
   localparam logic [7:0] ADDR_DEC_SRC = 8'd64;
   localparam logic [7:0] ADDR_DEC_DST = 8'd94;
   localparam logic [7:0] ADDR_STR     = 8'd128;
   localparam logic [7:0] ADDR_PAT     = 8'd160;
   localparam logic [7:0] ADDR_CNT_IN  = 8'd192;
   localparam logic [7:0] ADDR_CNT_ANY = 8'd193;
   localparam logic [7:0] ADDR_CNT_ALL = 8'd194;

   // Codeword bit index equals Hamming position; bit 0 carries overall parity p16.
   function automatic logic [15:0] hamming_enc(input logic [11:1] d);
      logic p8, p4, p2, p1, p16;
      p8  = ^d[11:5];
      p4  = ^{d[11:8], d[4:2]};
      p2  = ^{d[11], d[10], d[7], d[6], d[4], d[3], d[1]};
      p1  = ^{d[11], d[9], d[7], d[5], d[4], d[2], d[1]};
      p16 = ^{d, p8, p4, p2, p1};
      return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p16};
   endfunction

   // Bit 0 contributes index 0, so including it leaves the syndrome unchanged.
   function automatic logic [3:0] syndrome(input logic [15:0] c);
      logic [3:0] s;
      s = '0;
      for (int k = 0; k < 16; k++) begin
         if (c[k]) s = s ^ 4'(k);
      end
      return s;
   endfunction

   // A zero syndrome with odd overall parity points at bit 0, so one flip covers p16 too.
   function automatic logic [15:0] hamming_dec(input logic [15:0] c);
      logic [15:0] cc;
      logic [3:0]  s;
      logic        flag;
      s    = syndrome(c);
      cc   = c;
      flag = 1'b0;
      if (^c) cc[s] = ~cc[s];
      else if (s != 4'd0) flag = 1'b1;
      return {flag, 4'b0000, cc[15:9], cc[7:5], cc[3]};
   endfunction

endpackage

// File: rtl/top_level_data_mem.sv
// 256-byte data memory: combinational read, synchronous write, contents never reset.
module data_mem
   import top_level_pkg::*;
(
   input  logic       CLK,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata
);

   logic [7:0] core [0:255];

   // Single write port shared with the read address.
   always_ff @(posedge CLK) begin
      if (we) core[addr] <= wdata;
   end

   assign rdata = core[addr];

endmodule

// File: rtl/top_level.sv
// Three-task engine: SECDED encode, SECDED decode/correct, 5-bit pattern count.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_ENC    | encode 15 words: read lo, read hi, write lo, write hi
// ST_DEC    | decode 15 words, same four-phase access pattern
// ST_PAT_RD | one cycle to fetch pat, then one cycle per string byte
// ST_PAT_WR | write the three counters
// ST_FIN    | done held high; behaves like ST_IDLE
module top_level
   import top_level_pkg::*;
(
   input  logic CLK,
   input  logic reset_n,
   input  logic start,
   output logic done
);

   state_t      state;
   task_t       task_sel;
   task_t       task_next;
   logic [3:0]  words_left;
   logic [1:0]  phase;
   logic [5:0]  rd_left;
   logic [1:0]  wr_left;
   logic [7:0]  lo_byte;
   logic [7:0]  hi_byte;
   logic [4:0]  pat;
   logic [3:0]  prev_lo;
   logic [7:0]  cnt_in;
   logic [7:0]  cnt_any;
   logic [7:0]  cnt_all;

   logic [3:0]  idx;
   logic [7:0]  off;
   logic [4:0]  byte_idx;
   logic [15:0] enc_word;
   logic [15:0] dec_word;
   logic [11:0] win12;
   logic [2:0]  in_hits;
   logic [2:0]  span_hits;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   data_mem data_mem1 (
      .CLK   (CLK),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   assign idx      = 4'd15 - words_left;
   assign off      = {3'b000, idx, 1'b0};
   assign byte_idx = 5'(6'd32 - rd_left);
   assign enc_word = hamming_enc({hi_byte[2:0], lo_byte});
   assign dec_word = hamming_dec({hi_byte, lo_byte});

   // Rotation order of the tasks.
   always_comb begin
      task_next = TASK_ENC;
      case (task_sel)
         TASK_ENC: task_next = TASK_DEC;
         TASK_DEC: task_next = TASK_PAT;
         default:  task_next = TASK_ENC;
      endcase
   end

   // Window matches for the byte on the read port; spanning windows need a previous byte.
   always_comb begin
      win12     = {prev_lo, mem_rdata};
      in_hits   = '0;
      span_hits = '0;
      for (int j = 0; j < 4; j++) begin
         if (mem_rdata[j +: 5] == pat) in_hits = in_hits + 3'd1;
         if ((win12[j + 4 +: 5] == pat) && (byte_idx != 5'd0)) span_hits = span_hits + 3'd1;
      end
   end

   // Memory port steering from state and counters.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         ST_ENC, ST_DEC: begin
            case (phase)
               2'd0: mem_addr = ((state == ST_ENC) ? ADDR_ENC_SRC : ADDR_DEC_SRC) + off;
               2'd1: mem_addr = ((state == ST_ENC) ? ADDR_ENC_SRC : ADDR_DEC_SRC) + off + 8'd1;
               2'd2: begin
                  mem_we    = 1'b1;
                  mem_addr  = ((state == ST_ENC) ? ADDR_ENC_DST : ADDR_DEC_DST) + off;
                  mem_wdata = (state == ST_ENC) ? enc_word[7:0] : dec_word[7:0];
               end
               default: begin
                  mem_we    = 1'b1;
                  mem_addr  = ((state == ST_ENC) ? ADDR_ENC_DST : ADDR_DEC_DST) + off + 8'd1;
                  mem_wdata = (state == ST_ENC) ? enc_word[15:8] : dec_word[15:8];
               end
            endcase
         end
         ST_PAT_RD: mem_addr = (rd_left == 6'd33) ? ADDR_PAT : ADDR_STR + 8'(byte_idx);
         ST_PAT_WR: begin
            case (wr_left)
               2'd3: begin mem_we = 1'b1; mem_addr = ADDR_CNT_IN;  mem_wdata = cnt_in;  end
               2'd2: begin mem_we = 1'b1; mem_addr = ADDR_CNT_ANY; mem_wdata = cnt_any; end
               2'd1: begin mem_we = 1'b1; mem_addr = ADDR_CNT_ALL; mem_wdata = cnt_all; end
               default: mem_we = 1'b0;
            endcase
         end
         default: mem_we = 1'b0;
      endcase
   end

   // Sequencer; each loop spends one extra cycle on its empty terminal count before FIN.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         task_sel   <= TASK_ENC;
         done       <= 1'b0;
         words_left <= '0;
         phase      <= '0;
         rd_left    <= '0;
         wr_left    <= '0;
         lo_byte    <= '0;
         hi_byte    <= '0;
         pat        <= '0;
         prev_lo    <= '0;
         cnt_in     <= '0;
         cnt_any    <= '0;
         cnt_all    <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_FIN: begin
               if (start) begin
                  done       <= 1'b0;
                  words_left <= 4'd15;
                  phase      <= 2'd0;
                  rd_left    <= 6'd33;
                  wr_left    <= 2'd3;
                  cnt_in     <= '0;
                  cnt_any    <= '0;
                  cnt_all    <= '0;
                  case (task_sel)
                     TASK_ENC: state <= ST_ENC;
                     TASK_DEC: state <= ST_DEC;
                     default:  state <= ST_PAT_RD;
                  endcase
               end
            end
            ST_ENC, ST_DEC: begin
               case (phase)
                  2'd0: begin
                     if (words_left == 4'd0) begin
                        state    <= ST_FIN;
                        done     <= 1'b1;
                        task_sel <= task_next;
                     end else begin
                        lo_byte <= mem_rdata;
                        phase   <= 2'd1;
                     end
                  end
                  2'd1: begin
                     hi_byte <= mem_rdata;
                     phase   <= 2'd2;
                  end
                  2'd2: phase <= 2'd3;
                  default: begin
                     phase      <= 2'd0;
                     words_left <= words_left - 4'd1;
                  end
               endcase
            end
            ST_PAT_RD: begin
               if (rd_left == 6'd33) begin
                  pat <= mem_rdata[4:0];
               end else begin
                  cnt_in  <= cnt_in + 8'(in_hits);
                  cnt_all <= cnt_all + 8'(in_hits) + 8'(span_hits);
                  if (in_hits != 3'd0) cnt_any <= cnt_any + 8'd1;
                  prev_lo <= mem_rdata[3:0];
               end
               rd_left <= rd_left - 6'd1;
               if (rd_left == 6'd1) state <= ST_PAT_WR;
            end
            ST_PAT_WR: begin
               if (wr_left == 2'd0) begin
                  state    <= ST_FIN;
                  done     <= 1'b1;
                  task_sel <= task_next;
               end else begin
                  wr_left <= wr_left - 2'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: directed vector table plus randomized runs against a position-based model.
module tb_top_level;

   logic CLK = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        is_dec;
      logic [15:0] vin;
      logic [15:0] vexp;
   } vec_t;

   vec_t        vecs [6];
   logic [15:0] exp_enc [15];
   logic [15:0] exp_dec [15];

   top_level dut (
      .CLK     (CLK),
      .reset_n (reset_n),
      .start   (start),
      .done    (done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic mem_set(input int a, input logic [7:0] v);
      logic [7:0] a8;
      a8 = 8'(a);
      dut.data_mem1.core[a8] = v;
   endtask

   function automatic logic [7:0] mem_get(input int a);
      logic [7:0] a8;
      a8 = 8'(a);
      return dut.data_mem1.core[a8];
   endfunction

   // Data bits fill the non-power-of-two positions 3..15 in order; each parity covers its index bit.
   function automatic logic [15:0] m_enc(input logic [10:0] d);
      logic [15:0] c;
      logic        par;
      int          n;
      c = '0;
      n = 0;
      for (int p = 3; p < 16; p++) begin
         if ((p & (p - 1)) != 0) begin
            c[p] = d[n];
            n++;
         end
      end
      for (int j = 0; j < 4; j++) begin
         par = 1'b0;
         for (int p = 1; p < 16; p++) begin
            if (((p >> j) & 1) == 1 && p != (1 << j)) par = par ^ c[p];
         end
         c[1 << j] = par;
      end
      c[0] = ^c[15:1];
      return c;
   endfunction

   function automatic logic [10:0] m_data(input logic [15:0] c);
      logic [10:0] d;
      int          n;
      d = '0;
      n = 0;
      for (int p = 3; p < 16; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[n] = c[p];
            n++;
         end
      end
      return d;
   endfunction

   task automatic prep_enc(input bit use_table);
      int          slot;
      logic [10:0] d;
      slot = 0;
      if (use_table) begin
         for (int v = 0; v < 6; v++) begin
            if (!vecs[v].is_dec) begin
               d = vecs[v].vin[10:0];
               mem_set(2 * slot, d[7:0]);
               mem_set(2 * slot + 1, {5'($urandom), d[10:8]});
               exp_enc[slot] = vecs[v].vexp;
               slot++;
            end
         end
      end
      for (int i = slot; i < 15; i++) begin
         d = 11'($urandom);
         mem_set(2 * i, d[7:0]);
         mem_set(2 * i + 1, {5'($urandom), d[10:8]});
         exp_enc[i] = m_enc(d);
      end
      for (int i = 30; i < 60; i++) mem_set(i, 8'hA5);
   endtask

   task automatic prep_dec(input bit use_table);
      int          slot, nf, p1, p2;
      logic [10:0] d;
      logic [15:0] cw;
      slot = 0;
      if (use_table) begin
         for (int v = 0; v < 6; v++) begin
            if (vecs[v].is_dec) begin
               mem_set(64 + 2 * slot, vecs[v].vin[7:0]);
               mem_set(65 + 2 * slot, vecs[v].vin[15:8]);
               exp_dec[slot] = vecs[v].vexp;
               slot++;
            end
         end
      end
      for (int i = slot; i < 15; i++) begin
         d  = 11'($urandom);
         cw = m_enc(d);
         nf = int'($urandom_range(0, 2));
         p1 = int'($urandom_range(0, 15));
         p2 = (p1 + int'($urandom_range(1, 15))) % 16;
         if (nf >= 1) cw[p1] = ~cw[p1];
         if (nf == 2) cw[p2] = ~cw[p2];
         mem_set(64 + 2 * i, cw[7:0]);
         mem_set(65 + 2 * i, cw[15:8]);
         exp_dec[i] = (nf == 2) ? {1'b1, 4'b0000, m_data(cw)} : {5'b00000, d};
      end
      for (int i = 94; i < 124; i++) mem_set(i, 8'h5A);
   endtask

   // mode 0: zeros / pat 0, mode 1: 0x55 / pat 10101, mode 2: random
   task automatic prep_pat(input int mode);
      for (int k = 0; k < 32; k++) begin
         case (mode)
            0:       mem_set(128 + k, 8'h00);
            1:       mem_set(128 + k, 8'h55);
            default: mem_set(128 + k, 8'($urandom));
         endcase
      end
      case (mode)
         0:       mem_set(160, {3'($urandom), 5'b00000});
         1:       mem_set(160, {3'($urandom), 5'b10101});
         default: mem_set(160, 8'($urandom));
      endcase
      for (int i = 192; i < 195; i++) mem_set(i, 8'hEE);
   endtask

   // Slides a 5-bit window over the 256-bit string, MSB first.
   task automatic model_pat(output int e_in, output int e_any, output int e_all);
      logic       s [0:255];
      logic       hit [0:31];
      logic [7:0] b, pb;
      logic [4:0] pat, w5;
      pb  = mem_get(160);
      pat = pb[4:0];
      for (int k = 0; k < 32; k++) begin
         b = mem_get(128 + k);
         hit[k] = 1'b0;
         for (int i = 0; i < 8; i++) s[8 * k + 7 - i] = b[i];
      end
      e_in = 0; e_any = 0; e_all = 0;
      for (int w = 0; w < 252; w++) begin
         for (int i = 0; i < 5; i++) w5[4 - i] = s[w + i];
         if (w5 == pat) begin
            e_all++;
            if (w / 8 == (w + 4) / 8) begin
               e_in++;
               hit[w / 8] = 1'b1;
            end
         end
      end
      for (int k = 0; k < 32; k++) if (hit[k]) e_any++;
   endtask

   task automatic check_enc(input string tag);
      for (int i = 0; i < 15; i++)
         chk($sformatf("%s_enc_w%0d", tag, i), 32'({mem_get(31 + 2 * i), mem_get(30 + 2 * i)}), 32'(exp_enc[i]));
   endtask

   task automatic check_dec(input string tag);
      for (int i = 0; i < 15; i++)
         chk($sformatf("%s_dec_w%0d", tag, i), 32'({mem_get(95 + 2 * i), mem_get(94 + 2 * i)}), 32'(exp_dec[i]));
   endtask

   task automatic check_pat(input string tag, input int e_in, input int e_any, input int e_all);
      chk({tag, "_cnt192"}, 32'(mem_get(192)), 32'(e_in));
      chk({tag, "_cnt193"}, 32'(mem_get(193)), 32'(e_any));
      chk({tag, "_cnt194"}, 32'(mem_get(194)), 32'(e_all));
   endtask

   task automatic check_pat_model(input string tag);
      int e_in, e_any, e_all;
      model_pat(e_in, e_any, e_all);
      check_pat(tag, e_in, e_any, e_all);
   endtask

   // Launch one task, optionally holding start or poking it mid-run, and measure latency to done.
   task automatic run_task(input string tag, input int hold, input int busy_at, input int lat);
      int cyc;
      @(negedge CLK);
      start = 1'b1;
      @(posedge CLK);
      #1;
      chk({tag, "_done_drop"}, 32'(done), 32'd0);
      cyc = 0;
      for (int i = 1; i < hold; i++) begin
         @(posedge CLK);
         #1;
         cyc++;
      end
      start = 1'b0;
      while (!done && cyc < 200) begin
         @(posedge CLK);
         #1;
         cyc++;
         start = (busy_at != 0 && cyc == busy_at);
      end
      start = 1'b0;
      chk({tag, "_latency"}, 32'(cyc), 32'(lat));
   endtask

   initial begin
      vecs[0] = '{1'b0, 16'h0001, 16'h000F};
      vecs[1] = '{1'b0, 16'h07FF, 16'hFFFF};
      vecs[2] = '{1'b0, 16'h0000, 16'h0000};
      vecs[3] = '{1'b1, 16'h002F, 16'h0001};
      vecs[4] = '{1'b1, 16'h000E, 16'h0001};
      vecs[5] = '{1'b1, 16'h0009, 16'h8001};

      repeat (3) @(posedge CLK);
      #1;
      chk("reset_done", 32'(done), 32'd0);
      @(negedge CLK);
      reset_n = 1'b1;

      prep_enc(1'b1);
      prep_dec(1'b1);
      prep_pat(0);
      run_task("t1", 1, 0, 61);
      check_enc("t1");
      run_task("t2_hold", 3, 0, 61);
      check_dec("t2_hold");
      run_task("t3_zero", 1, 0, 37);
      check_pat("t3_zero", 128, 32, 252);

      prep_enc(1'b0);
      for (int i = 94; i < 124; i++) mem_set(i, 8'h5A);
      run_task("t1_rot", 1, 20, 61);
      check_enc("t1_rot");
      chk("t1_rot_dec_untouched", 32'(mem_get(94)), 32'h5A);

      prep_dec(1'b0);
      run_task("t2_busy", 1, 30, 61);
      check_dec("t2_busy");
      prep_pat(1);
      run_task("t3_alt", 1, 0, 37);
      check_pat("t3_alt", 64, 32, 126);

      for (int r = 0; r < 2; r++) begin
         prep_enc(1'b0);
         prep_dec(1'b0);
         prep_pat(2);
         run_task($sformatf("r%0d_t1", r), 1, 0, 61);
         check_enc($sformatf("r%0d", r));
         run_task($sformatf("r%0d_t2", r), 1, 0, 61);
         check_dec($sformatf("r%0d", r));
         run_task($sformatf("r%0d_t3", r), 1, 0, 37);
         check_pat_model($sformatf("r%0d", r));
      end

      // Reset in the middle of a decode run, then confirm the rotation restarts at encode.
      prep_enc(1'b0);
      run_task("pre_rst_t1", 1, 0, 61);
      prep_dec(1'b0);
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (10) @(negedge CLK);
      reset_n = 1'b0;
      #1;
      chk("mid_reset_done", 32'(done), 32'd0);
      @(negedge CLK);
      reset_n = 1'b1;
      prep_enc(1'b0);
      run_task("post_rst_t1", 1, 0, 61);
      check_enc("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
